fft_r22sdf_twiddle_ctrl: RTL and testbench



---
 rtl/fft_r22sdf_pkg.sv | 37 +++
 rtl/fft_r22sdf_twiddle_ctrl_if.sv | 38 +++
 rtl/fft_twiddle_fold.sv | 22 ++
 rtl/fft_r22sdf_twiddle_ctrl.sv | 130 +++++++++++++
 tb/tb_fft_r22sdf_twiddle_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fft_r22sdf_pkg.sv
// Shared types and helpers for the R2^2SDF twiddle sequencer.
// Optional build macro used by the slice: FFT_TWIDDLE_QUAD_FOLD_EN.
package fft_r22sdf_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tw_state_e;

  typedef struct packed {
    logic swap;
    logic neg_re;
    logic neg_im;
  } fold_flags_t;

  // Per-sample exponent step m(q): the bit-reversed quadrant index.
  function automatic logic [1:0] quad_step(input logic [1:0] q);
    logic [1:0] m;
    case (q)
      2'd0:    m = 2'd0;
      2'd1:    m = 2'd2;
      2'd2:    m = 2'd1;
      2'd3:    m = 2'd3;
      default: m = 2'd0;
    endcase
    return m;
  endfunction

  function automatic int addr_width(input int nlog2, input bit fold_en);
    if (fold_en) begin
      return nlog2 - 32'sd2;
    end else begin
      return nlog2;
    end
  endfunction

endpackage

// File: rtl/fft_r22sdf_twiddle_ctrl_if.sv
// Sample handshake and twiddle outputs of the twiddle sequencer.
// Fold flag wires exist only when FFT_TWIDDLE_QUAD_FOLD_EN is defined.
interface fft_r22sdf_twiddle_ctrl_if #(
  parameter int NLOG2  = 10,
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
  parameter int ADDR_W = NLOG2 - 2
`else
  parameter int ADDR_W = NLOG2
`endif
);
  logic              valid_i;
  logic              sync_i;
  logic              valid_o;
  logic              sof_o;
  logic [NLOG2-1:0]  ctr_o;
  logic [ADDR_W-1:0] w_addr_o;
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
  logic              w_swap_o;
  logic              w_neg_re_o;
  logic              w_neg_im_o;
`endif

  modport master (
    output valid_i, sync_i,
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
    input  w_swap_o, w_neg_re_o, w_neg_im_o,
`endif
    input  valid_o, sof_o, ctr_o, w_addr_o
  );

  modport slave (
    input  valid_i, sync_i,
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
    output w_swap_o, w_neg_re_o, w_neg_im_o,
`endif
    output valid_o, sof_o, ctr_o, w_addr_o
  );
endinterface

// File: rtl/fft_twiddle_fold.sv
// Maps a full-circle exponent e onto a quarter-circle ROM offset plus
// swap/negate flags (downstream swaps re/im first, then negates).
module fft_twiddle_fold
  import fft_r22sdf_pkg::*;
#(
  parameter int NLOG2 = 10
) (
  input  logic [NLOG2-1:0] e,
  output logic [NLOG2-3:0] offset,
  output fold_flags_t      flags
);
  logic [1:0] quad_s;

  // Quadrant p selects the symmetry used to reach the first-quadrant entry.
  always_comb begin
    quad_s       = e[NLOG2-1:NLOG2-2];
    offset       = e[NLOG2-3:0];
    flags.swap   = quad_s[0];
    flags.neg_re = quad_s[1];
    flags.neg_im = quad_s[1] ^ quad_s[0];
  end
endmodule

// File: rtl/fft_r22sdf_twiddle_ctrl.sv
// Twiddle sequencer for one R2^2SDF multiplier stage: sample counter plus
// accumulator-generated ROM address; FFT_TWIDDLE_QUAD_FOLD_EN adds quadrant folding.
module fft_r22sdf_twiddle_ctrl
  import fft_r22sdf_pkg::*;
#(
  parameter int FFT_N = 1024,
  parameter int NLOG2 = 10
) (
  input logic                      clk_i,
  input logic                      rst_n,
  fft_r22sdf_twiddle_ctrl_if.slave tw
);
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
  localparam bit FOLD_EN = 1'b1;
`else
  localparam bit FOLD_EN = 1'b0;
`endif
  localparam int ADDR_W = addr_width(NLOG2, FOLD_EN);
  localparam int R_W    = NLOG2 - 2;

  if ((2 ** NLOG2) != FFT_N || FFT_N < 16) begin : g_bad_cfg
    $error("fft_r22sdf_twiddle_ctrl: FFT_N must equal 2**NLOG2 and be >= 16");
  end

  tw_state_e         state_r, state_s;
  logic [NLOG2-1:0]  ctr_r, ctr_s;
  logic [NLOG2-1:0]  acc_r, acc_s;
  logic              pend_r, pend_s;
  logic              restart_s;
  logic [NLOG2-1:0]  n_s;
  logic [NLOG2-1:0]  e_s;
  logic [ADDR_W-1:0] addr_map_s;

  logic              valid_r, valid_s;
  logic              sof_r, sof_s;
  logic [NLOG2-1:0]  idx_r, idx_s;
  logic [ADDR_W-1:0] addr_r, addr_s;

`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
  fold_flags_t fold_s;
  fold_flags_t flags_r, flags_s;

  fft_twiddle_fold #(.NLOG2(NLOG2)) u_fold (
    .e      (e_s),
    .offset (addr_map_s),
    .flags  (fold_s)
  );
`else
  assign addr_map_s = e_s;
`endif

  // Next-state: restart on IDLE/pending/sync, then advance index and exponent.
  always_comb begin
    state_s   = state_r;
    ctr_s     = ctr_r;
    acc_s     = acc_r;
    pend_s    = pend_r;
    valid_s   = 1'b0;
    sof_s     = sof_r;
    idx_s     = idx_r;
    addr_s    = addr_r;
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
    flags_s   = flags_r;
`endif
    restart_s = (state_r == ST_IDLE) | pend_r | tw.sync_i;
    n_s       = restart_s ? {NLOG2{1'b0}} : ctr_r;
    e_s       = restart_s ? {NLOG2{1'b0}} : acc_r;

    if (tw.valid_i) begin
      state_s = ST_RUN;
      pend_s  = 1'b0;
      ctr_s   = n_s + {{(NLOG2-1){1'b0}}, 1'b1};
      if (&n_s[R_W-1:0]) begin
        acc_s = {NLOG2{1'b0}};
      end else begin
        acc_s = e_s + {{(NLOG2-2){1'b0}}, quad_step(n_s[NLOG2-1:NLOG2-2])};
      end
      valid_s = 1'b1;
      sof_s   = (n_s == {NLOG2{1'b0}});
      idx_s   = n_s;
      addr_s  = addr_map_s;
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
      flags_s = fold_s;
`endif
    end else if (tw.sync_i) begin
      pend_s = 1'b1;
    end else begin
      pend_s = pend_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ctr_r   <= {NLOG2{1'b0}};
      acc_r   <= {NLOG2{1'b0}};
      pend_r  <= 1'b0;
      valid_r <= 1'b0;
      sof_r   <= 1'b0;
      idx_r   <= {NLOG2{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
      flags_r <= 3'b000;
`endif
    end else begin
      state_r <= state_s;
      ctr_r   <= ctr_s;
      acc_r   <= acc_s;
      pend_r  <= pend_s;
      valid_r <= valid_s;
      sof_r   <= sof_s;
      idx_r   <= idx_s;
      addr_r  <= addr_s;
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
      flags_r <= flags_s;
`endif
    end
  end

  assign tw.valid_o    = valid_r;
  assign tw.sof_o      = sof_r;
  assign tw.ctr_o      = idx_r;
  assign tw.w_addr_o   = addr_r;
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
  assign tw.w_swap_o   = flags_r.swap;
  assign tw.w_neg_re_o = flags_r.neg_re;
  assign tw.w_neg_im_o = flags_r.neg_im;
`endif
endmodule

// File: tb/tb_fft_r22sdf_twiddle_ctrl.sv
// Randomised self-checking bench for fft_r22sdf_twiddle_ctrl (FFT_N=16),
// valid with or without FFT_TWIDDLE_QUAD_FOLD_EN.
module tb_fft_r22sdf_twiddle_ctrl;
  localparam int N  = 16;
  localparam int NL = 4;
  localparam int Q  = N / 4;
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
  localparam int AW = NL - 2;
`else
  localparam int AW = NL;
`endif
  localparam int TBL [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  int exp_valid = 0, exp_sof = 0, exp_ctr = 0, exp_addr = 0;
  int exp_swap = 0, exp_nre = 0, exp_nim = 0;
  int m_next = 0;
  bit m_pend = 1'b0;

  fft_r22sdf_twiddle_ctrl_if #(.NLOG2(NL), .ADDR_W(AW)) bus ();

  fft_r22sdf_twiddle_ctrl #(.FFT_N(N), .NLOG2(NL)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .tw    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // Exponent straight from the definition e = r * bitrev(q).
  function automatic int model_e(input int n);
    int q, r, m;
    q = n / Q;
    r = n % Q;
    m = (q == 1) ? 2 : (q == 2) ? 1 : q;
    return r * m;
  endfunction

  task automatic model(input bit v, input bit s, input bit r);
    int idx, e, p;
    if (!r) begin
      exp_valid = 0; exp_sof = 0; exp_ctr = 0; exp_addr = 0;
      exp_swap = 0; exp_nre = 0; exp_nim = 0;
      m_next = 0; m_pend = 1'b0;
    end else begin
      exp_valid = v ? 1 : 0;
      if (v) begin
        idx = (s || m_pend) ? 0 : m_next;
        m_pend = 1'b0;
        m_next = (idx + 1) % N;
        e = model_e(idx);
        p = e / Q;
        exp_sof = (idx == 0) ? 1 : 0;
        exp_ctr = idx;
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
        exp_addr = e % Q;
`else
        exp_addr = e;
`endif
        exp_swap = p % 2;
        exp_nre  = (p >= 2) ? 1 : 0;
        exp_nim  = (p == 1 || p == 2) ? 1 : 0;
      end else if (s) begin
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic step(input bit v, input bit s, input bit r);
    bus.valid_i = v;
    bus.sync_i  = s;
    rst_n       = r;
    @(posedge clk);
    #1;
    model(v, s, r);
    chk_en = 1'b1;
  endtask

  // Every cycle: DUT outputs against the behavioural model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_o", int'(bus.valid_o), exp_valid);
      chk("sof_o", int'(bus.sof_o), exp_sof);
      chk("ctr_o", int'(bus.ctr_o), exp_ctr);
      chk("w_addr_o", int'(bus.w_addr_o), exp_addr);
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
      chk("w_swap_o", int'(bus.w_swap_o), exp_swap);
      chk("w_neg_re_o", int'(bus.w_neg_re_o), exp_nre);
      chk("w_neg_im_o", int'(bus.w_neg_im_o), exp_nim);
`endif
    end
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.sync_i  = 1'b0;
    for (int i = 0; i < 16; i++) chk("model_e_table", model_e(i), TBL[i]);

    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_ctr", int'(bus.ctr_o), 0);
    chk("rst_addr", int'(bus.w_addr_o), 0);

    // Back-to-back frame with hand-computed spot checks.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == 0) chk("first_sof", int'(bus.sof_o), 1);
      if (i == 1) chk("second_sof", int'(bus.sof_o), 0);
      chk("frame_ctr", int'(bus.ctr_o), i);
`ifdef FFT_TWIDDLE_QUAD_FOLD_EN
      if (i == 15) begin
        chk("e9_addr", int'(bus.w_addr_o), 1);
        chk("e9_swap", int'(bus.w_swap_o), 0);
        chk("e9_neg_re", int'(bus.w_neg_re_o), 1);
        chk("e9_neg_im", int'(bus.w_neg_im_o), 1);
      end
      if (i == 14) begin
        chk("e6_addr", int'(bus.w_addr_o), 2);
        chk("e6_swap", int'(bus.w_swap_o), 1);
        chk("e6_neg_re", int'(bus.w_neg_re_o), 0);
        chk("e6_neg_im", int'(bus.w_neg_im_o), 1);
      end
      if (i == 6) begin
        chk("e4_addr", int'(bus.w_addr_o), 0);
        chk("e4_swap", int'(bus.w_swap_o), 1);
        chk("e4_neg_im", int'(bus.w_neg_im_o), 1);
      end
`else
      chk("frame_addr", int'(bus.w_addr_o), TBL[i]);
`endif
    end

    // Gap every third cycle; the model holds outputs across gaps.
    for (int c = 0; c < 24; c++) step((c % 3) != 2, 1'b0, 1'b1);

    // Sync without valid at n=7.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("pend_hold_valid", int'(bus.valid_o), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("pend_ctr", int'(bus.ctr_o), 0);
    chk("pend_sof", int'(bus.sof_o), 1);
    chk("pend_addr", int'(bus.w_addr_o), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("pend_next_ctr", int'(bus.ctr_o), 1);

    // Sync coincident with the natural wrap.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("wrap_sync_ctr", int'(bus.ctr_o), 0);
    chk("wrap_sync_sof", int'(bus.sof_o), 1);
    step(1'b1, 1'b0, 1'b1);
    chk("wrap_sync_next", int'(bus.ctr_o), 1);

    // Reset mid-frame at n=10.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_valid", int'(bus.valid_o), 0);
    chk("midrst_ctr", int'(bus.ctr_o), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_restart", int'(bus.ctr_o), 0);
    chk("midrst_sof", int'(bus.sof_o), 1);

    // Random traffic with occasional sync and reset.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) != 0);
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
